fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 0, is the byte address of the first fetch after reset.
REQ-002 Parameter DEPTH, default 2, is the number of fetch-buffer entries (legal values: 2 to 8).
REQ-003 Port clk, input, 1 bit: single clock; all state updates occur on the rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port rom_address, output, RomAddress: byte address driven to the combinational instruction ROM.
REQ-006 Port rom_data, input, UWord (32 bits): ROM word for rom_address, valid in the same cycle.
REQ-007 Port redirect_valid, input, 1 bit: request to flush and restart fetch at redirect_target.
REQ-008 Port redirect_target, input, RomAddress: new fetch byte address.
REQ-009 Port out_valid, output, 1 bit: the buffer head holds an instruction.
REQ-010 Port out_ready, input, 1 bit: decode accepts the head this cycle.
REQ-011 Port out_pc, output, RomAddress: byte address of the head instruction.
REQ-012 Port out_instr, output, UWord: head instruction word.
REQ-013 Port fetch_fault, output, 1 bit: sticky flag for a misaligned redirect target.

Function
REQ-014 The block SHALL hold a PC register and drive rom_address = PC combinationally.
REQ-015 The block SHALL keep a FIFO of {pc, instr} entries with occupancy count 0..DEPTH.
REQ-016 out_valid SHALL equal (count != 0), and out_pc/out_instr SHALL come from the head entry; they depend on registered state only.
REQ-017 pop SHALL equal out_valid AND out_ready.
REQ-018 push SHALL equal NOT fault AND NOT redirect_valid AND (count < DEPTH OR pop).
REQ-019 On push, the block SHALL write {PC, rom_data} at the tail and set PC <= PC + 4, modulo 2^$bits(RomAddress); wrap-around from the top address to 0 is silent.
REQ-020 Fetch-to-output latency SHALL be 1 cycle: a word read at edge N is visible on out_* after edge N.
REQ-021 With out_ready held at 1 and no redirect, the block SHALL sustain one instruction per cycle.
REQ-022 If push and pop occur together, count SHALL be unchanged; a full buffer SHALL still accept a push when it pops in the same cycle.
REQ-023 While out_valid=1 and out_ready=0, out_pc and out_instr SHALL stay stable.
REQ-024 A redirect_valid edge with an aligned target (low 2 bits 00) SHALL:
  - flush all entries (count <= 0);
  - set PC <= redirect_target;
  - perform no push that cycle.
REQ-025 A pop that coincides with a redirect SHALL count as a completed transfer to decode.
REQ-026 A redirect edge with a misaligned target SHALL flush, leave PC unchanged, and set fault/fetch_fault to 1.
REQ-027 While fault=1 there SHALL be no pushes; only a later aligned redirect SHALL clear fault and resume at its target.
REQ-028 Redirect SHALL have priority over push and over buffer retention.

Reset
REQ-029 When reset is asserted, the block SHALL immediately set PC = RESET_PC, count = 0, fault = 0, out_valid = 0, and fetch_fault = 0.
REQ-030 Buffer data contents need not be reset; out_pc/out_instr are don't-care while out_valid=0.
REQ-031 The first push SHALL occur at the first rising edge with reset low.
REQ-032 Reset asserted mid-stream SHALL discard all entries and any pending fault.

Verification
REQ-033 Streaming: ROM words 0x00000013, 0x00100093 and 0x00200113 at addresses 0, 4 and 8, out_ready=1. Required: out_valid rises 1 cycle after reset release, then out_pc = 0, 4, 8 in consecutive cycles with the matching out_instr.
REQ-034 Backpressure, DEPTH=2, out_ready=0 for 5 cycles. Required: count saturates at 2; rom_address holds 8; out_pc stays 0. After out_ready=1: out_pc = 0, 4, 8 with no loss or duplication.
REQ-035 Redirect: redirect to 0x40 while the buffer holds pc 4 and 8. Required: next cycle out_valid=0. The cycle after that: out_pc = 0x40 with instr = ROM[0x40].
REQ-036 Fault: redirect to 0x42. Required: fetch_fault = 1, and out_valid stays 0 for 10 cycles. Then redirect to 0x10: fetch_fault = 0 and out_pc = 0x10 one cycle after it.
REQ-037 Wrap and reset: RESET_PC = top aligned address, out_ready=1. Required: out_pc goes top then 0. Asynchronous reset pulse mid-stream: out_valid = 0 immediately, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives a combinational ROM from the PC and queues
// fetched {pc, instr} pairs in a small FIFO for decode. Redirects flush the
// FIFO and restart fetch; a misaligned redirect target parks fetch in a
// sticky fault until an aligned redirect arrives.
module fetch_stage #(
    parameter int unsigned               ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]         RESET_PC = '0,
    parameter int unsigned               DEPTH    = 2      // 2..8 entries
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [31:0]       rom_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [31:0]       out_instr,
    output logic              fetch_fault
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

    logic [ADDR_W-1:0] pc;
    logic              fault;
    logic [CW-1:0]     count;
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;

    logic [ADDR_W-1:0] pc_mem    [DEPTH];
    logic [31:0]       instr_mem [DEPTH];

    logic push;
    logic pop;
    logic target_aligned;

    assign rom_address    = pc;
    assign out_valid      = (count != '0);
    assign out_pc         = pc_mem[head];
    assign out_instr      = instr_mem[head];
    assign fetch_fault    = fault;
    assign target_aligned = (redirect_target[1:0] == 2'b00);

    // Handshake decode; a full buffer may still push when it pops this cycle.
    always_comb begin
        pop  = out_valid && out_ready;
        push = !fault && !redirect_valid && ((count < FULL_CNT) || pop);
    end

    // PC, fault flag and FIFO bookkeeping; redirect overrides everything else.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= RESET_PC;
            fault <= 1'b0;
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else if (redirect_valid) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
            if (target_aligned) begin
                pc    <= redirect_target;
                fault <= 1'b0;
            end else begin
                fault <= 1'b1;
            end
        end else begin
            if (push) begin
                pc   <= pc + ADDR_W'(4);
                tail <= (tail == LAST_PTR) ? '0 : tail + PW'(1);
            end
            if (pop) begin
                head <= (head == LAST_PTR) ? '0 : head + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Entry storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail]    <= pc;
            instr_mem[tail] <= rom_data;
        end
    end

endmodule
